// File: rtl/ptw_two_level.sv
// ptw_two_level: two-level (Sv32-style) page-table walker; producer side of the TLB refill port.
// Latency: accept->refill 5 cycles with zero-wait memory (3 on an L1 cache hit / superpage / L1 fault).
// Backpressure: walk_req_ready only in IDLE; mem_req_valid/addr held until mem_req_ready; one read in flight.
// Ports: walk_req_* miss request; ptbr_pfn root table frame; mem_req_*/mem_resp_* PTE read port;
//        refill_en/vpn/pfn one-cycle TLB write; walk_done/walk_fault completion status;
//        walk_flush drops the cached L1 PTE.
// Optional: `define PTW_L1_CACHE_EN adds a one-entry cache of the last valid non-leaf L1 PTE,
//           tagged by {ptbr, vpn1}. Without it walk_flush is ignored and every walk reads L1.
module ptw_two_level #(
  parameter int VPN_WIDTH = 20,
  parameter int PFN_WIDTH = 20,
  parameter int PTE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   walk_req_valid,
  output logic                   walk_req_ready,
  input  logic [VPN_WIDTH-1:0]   walk_req_vpn,
  input  logic [PFN_WIDTH-1:0]   ptbr_pfn,
  input  logic                   walk_flush,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PFN_WIDTH+11:0]  mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [PTE_WIDTH-1:0]   mem_resp_data,
  output logic                   refill_en,
  output logic [VPN_WIDTH-1:0]   refill_vpn,
  output logic [PFN_WIDTH-1:0]   refill_pfn,
  output logic                   walk_done,
  output logic                   walk_fault
);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT
  } state_t;

  state_t               state;
  logic [VPN_WIDTH-1:0] vpn_q;
  logic [PFN_WIDTH-1:0] ptbr_q;

  // PTE field decode of the returning read data
  logic                 pte_v, pte_r, pte_w, pte_x;
  logic                 pte_leaf, pte_invalid;
  logic [PFN_WIDTH-1:0] pte_ppn;

  assign pte_v       = mem_resp_data[0];
  assign pte_r       = mem_resp_data[1];
  assign pte_w       = mem_resp_data[2];
  assign pte_x       = mem_resp_data[3];
  assign pte_ppn     = mem_resp_data[PFN_WIDTH+9:10];
  assign pte_leaf    = pte_r | pte_w | pte_x;
  assign pte_invalid = !pte_v || (pte_w && !pte_r);

  // Flag bits 9:4 and anything above the PPN carry no meaning for the walk.
  logic unused_bits;
  assign unused_bits = ^{mem_resp_data, walk_flush};

  assign walk_req_ready = (state == IDLE);

  logic                 cache_hit;
  logic [PFN_WIDTH-1:0] cache_ppn;

`ifdef PTW_L1_CACHE_EN
  logic                 cache_vld;
  logic [PFN_WIDTH+9:0] cache_tag;
  logic [PFN_WIDTH-1:0] cache_ppn_q;
  logic                 l1_fill;

  assign l1_fill = (state == L1_WAIT) && mem_resp_valid && !pte_invalid && !pte_leaf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld   <= 1'b0;
      cache_tag   <= '0;
      cache_ppn_q <= '0;
    end else begin
      if (l1_fill) begin
        cache_vld   <= 1'b1;
        cache_tag   <= {ptbr_q, vpn_q[VPN_WIDTH-1:10]};
        cache_ppn_q <= pte_ppn;
      end
      // Flush and fault win over a same-cycle fill.
      if (walk_flush || (state == FAULT)) begin
        cache_vld <= 1'b0;
      end
    end
  end

  // A flush arriving together with the request must not let the stale entry be used.
  assign cache_hit = cache_vld && !walk_flush &&
                     (cache_tag == {ptbr_pfn, walk_req_vpn[VPN_WIDTH-1:10]});
  assign cache_ppn = cache_ppn_q;
`else
  assign cache_hit = 1'b0;
  assign cache_ppn = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vpn_q         <= '0;
      ptbr_q        <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      refill_en     <= 1'b0;
      refill_vpn    <= '0;
      refill_pfn    <= '0;
      walk_done     <= 1'b0;
      walk_fault    <= 1'b0;
    end else begin
      // Completion strobes are single-cycle by default.
      refill_en  <= 1'b0;
      walk_done  <= 1'b0;
      walk_fault <= 1'b0;

      case (state)
        IDLE: begin
          if (walk_req_valid) begin
            vpn_q         <= walk_req_vpn;
            ptbr_q        <= ptbr_pfn;
            mem_req_valid <= 1'b1;
            if (cache_hit) begin
              mem_req_addr <= {cache_ppn, walk_req_vpn[9:0], 2'b00};
              state        <= L0_REQ;
            end else begin
              mem_req_addr <= {ptbr_pfn, walk_req_vpn[VPN_WIDTH-1:10], 2'b00};
              state        <= L1_REQ;
            end
          end
        end

        L1_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= L1_WAIT;
          end
        end

        L1_WAIT: begin
          if (mem_resp_valid) begin
            if (pte_invalid) begin
              walk_done  <= 1'b1;
              walk_fault <= 1'b1;
              state      <= FAULT;
            end else if (!pte_leaf) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {pte_ppn, vpn_q[9:0], 2'b00};
              state         <= L0_REQ;
            end else if (pte_ppn[9:0] != 10'd0) begin
              // Superpage leaf must be 4 MB aligned.
              walk_done  <= 1'b1;
              walk_fault <= 1'b1;
              state      <= FAULT;
            end else begin
              refill_en  <= 1'b1;
              walk_done  <= 1'b1;
              refill_vpn <= vpn_q;
              refill_pfn <= {pte_ppn[PFN_WIDTH-1:10], vpn_q[9:0]};
              state      <= DONE;
            end
          end
        end

        L0_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= L0_WAIT;
          end
        end

        L0_WAIT: begin
          if (mem_resp_valid) begin
            if (pte_invalid || !pte_leaf) begin
              walk_done  <= 1'b1;
              walk_fault <= 1'b1;
              state      <= FAULT;
            end else begin
              refill_en  <= 1'b1;
              walk_done  <= 1'b1;
              refill_vpn <= vpn_q;
              refill_pfn <= pte_ppn;
              state      <= DONE;
            end
          end
        end

        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
